uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receiver. It captures each completed byte from the receiver's data_out/rx_done pair into a DEPTH-entry FIFO. The FIFO presents the bytes to the host on a first-word-fall-through valid/ready interface. It also flags overrun and a character-timeout, based on the baud tick, when bytes sit unread on an idle line.

---
 rtl/uart_rx_fifo.sv | 126 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver. It captures one byte per rising
// edge of rx_done, presents the oldest byte first-word-fall-through on a
// valid/ready port, and flags overrun and character-timeout.
module uart_rx_fifo #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned TIMEOUT_TICKS = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              tick,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic              timeout
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              rx_done_q, rx_done_d;

    logic push;
    logic pop;
    logic wr_en;
    logic drop;

    // Next-state computation for pointers, occupancy, flags and the idle timer
    always_comb begin
        push       = rx_done & ~rx_done_q;
        pop        = rd_valid_q & rd_ready;
        // A full FIFO still accepts a byte when the host frees a slot this cycle
        wr_en      = push & (~full_q | pop);
        drop       = push & full_q & ~pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        to_cnt_d   = to_cnt_q;
        rx_done_d  = rx_done;

        if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        empty_d    = (count_d == CNT_W'(0));
        full_d     = (count_d == CNT_W'(DEPTH));
        rd_valid_d = ~empty_d;

        // Set wins over clear when a drop coincides with overrun_clr
        overrun_d  = drop | (overrun_q & ~overrun_clr);

        // Idle timer only runs while bytes sit unread with no traffic
        if (wr_en || pop || empty_q) begin
            to_cnt_d = TO_W'(0);
        end else if (tick && (to_cnt_q != TO_W'(TIMEOUT_TICKS))) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        timeout_d  = (to_cnt_d == TO_W'(TIMEOUT_TICKS));
    end

    // Control and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            to_cnt_q   <= '0;
            rx_done_q  <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            to_cnt_q   <= to_cnt_d;
            rx_done_q  <= rx_done_d;
        end
    end

    // Storage array, not reset; contents are meaningless while empty
    always_ff @(posedge clk) begin
        if (!reset && wr_en) mem_q[wr_ptr_q] <= rx_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign overrun  = overrun_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int TO     = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic              tick;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overrun;
    logic              overrun_clr;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    bit                m_ovr;
    bit                m_prev;
    int                m_idle;

    uart_rx_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .tick(tick), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .count(count), .full(full), .empty(empty),
        .overrun(overrun), .overrun_clr(overrun_clr), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("count",    32'(count),    32'(q.size()));
        chk("empty",    32'(empty),    32'(q.size() == 0));
        chk("full",     32'(full),     32'(q.size() == DEPTH));
        chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        chk("overrun",  32'(overrun),  32'(m_ovr));
        chk("timeout",  32'(timeout),  32'(m_idle == TO));
        if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
    endtask

    // One clock: apply the spec's rules to the model, then compare after the edge
    task automatic cyc();
        bit m_push, m_pop, acc, was_empty;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_ovr  = 0;
            m_idle = 0;
            m_prev = 1;
        end else begin
            m_push    = rx_done && !m_prev;
            m_prev    = rx_done;
            was_empty = (q.size() == 0);
            m_pop     = !was_empty && rd_ready;
            acc       = m_push && (q.size() < DEPTH || m_pop);
            if (m_pop) void'(q.pop_front());
            if (acc) q.push_back(rx_data);
            if (m_push && !acc) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
            if (acc || m_pop || was_empty) m_idle = 0;
            else if (tick && m_idle < TO) m_idle++;
        end
        #1;
        compare_all();
    endtask

    task automatic push_byte(input logic [DATA_W-1:0] b);
        rx_data = b;
        rx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
        cyc();
    endtask

    task automatic pop_byte(input logic [DATA_W-1:0] exp);
        chk("pop_data", 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_data = '0; rx_done = 1'b0; tick = 1'b0;
        rd_ready = 1'b0; overrun_clr = 1'b0;
        m_prev = 1; m_ovr = 0; m_idle = 0;
        cyc(); cyc();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        reset = 1'b0;
        cyc();

        // Three bytes in, drained in order
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        chk("abc_count", 32'(count), 32'd3);
        chk("abc_head",  32'(rd_data), 32'h41);
        pop_byte(8'h41); pop_byte(8'h42); pop_byte(8'h43);
        chk("abc_empty", 32'(empty), 32'd1);

        // Held rx_done gives exactly one push
        rx_data = 8'h55; rx_done = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        rx_done = 1'b0; cyc();
        chk("held_count", 32'(count), 32'd1);
        pop_byte(8'h55);

        // rx_done high across reset release gives no push
        rx_done = 1'b1; reset = 1'b1; cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("rst_held_count", 32'(count), 32'd0);
        rx_done = 1'b0; cyc();

        // Fill, overflow, drain, clear
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        push_byte(8'hFF);
        chk("ovf_full",    32'(full),    32'd1);
        chk("ovf_overrun", 32'(overrun), 32'd1);
        // Drop coinciding with clear keeps overrun set
        rx_data = 8'hEE; rx_done = 1'b1; overrun_clr = 1'b1; cyc();
        rx_done = 1'b0; overrun_clr = 1'b0; cyc();
        chk("set_wins", 32'(overrun), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_byte(8'(i));
        overrun_clr = 1'b1; cyc(); overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h80 + i));
        rx_data = 8'hA5; rx_done = 1'b1; rd_ready = 1'b1; cyc();
        rx_done = 1'b0; rd_ready = 1'b0; cyc();
        chk("pp_count",   32'(count),   32'd16);
        chk("pp_overrun", 32'(overrun), 32'd0);
        for (int i = 1; i < DEPTH; i++) pop_byte(8'(8'h80 + i));
        pop_byte(8'hA5);

        // Character timeout
        push_byte(8'h77);
        for (int i = 0; i < TO; i++) begin
            chk("to_before", 32'(timeout), 32'd0);
            tick = 1'b1; cyc(); tick = 1'b0; cyc();
        end
        chk("to_after", 32'(timeout), 32'd1);
        pop_byte(8'h77);
        chk("to_drop",  32'(timeout), 32'd0);
        chk("to_empty", 32'(empty),   32'd1);

        // Randomized traffic with wrap-around; model checks every cycle
        for (int i = 0; i < 600; i++) begin
            rx_data     = 8'($urandom);
            rx_done     = 1'($urandom % 2);
            rd_ready    = ($urandom % 3) == 0;
            tick        = ($urandom % 2) == 0;
            overrun_clr = ($urandom % 16) == 0;
            cyc();
        end

        // Mid-stream reset
        rx_done = 1'b0; rd_ready = 1'b0; tick = 1'b0; overrun_clr = 1'b0;
        push_byte(8'h11); push_byte(8'h22);
        reset = 1'b1; cyc();
        chk("mid_rst_count",   32'(count),   32'd0);
        chk("mid_rst_empty",   32'(empty),   32'd1);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0; cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
